// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        DONE,
        ERROR
    } loader_state_t;

    localparam int HDR_BYTES      = 4;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_assembler.sv
// Collects four bytes into a little-endian 32-bit word; word_valid marks the
// cycle in which the final lane is being captured, with the full word on `word`.
module byte_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  lane;
    logic [31:0] shreg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            lane  <= '0;
            shreg <= '0;
        end else if (clear) begin
            lane  <= '0;
            shreg <= '0;
        end else if (byte_en) begin
            lane  <= lane + 2'd1;
            shreg <= word;
        end
    end

    // Newest byte enters at the top, so after four shifts the first byte sits in [7:0].
    assign word       = {byte_in, shreg[31:8]};
    assign word_valid = byte_en && (lane == LAST_LANE);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a word-count header, streams words into instruction
// memory and holds the core in reset until the image is complete.
//
// state | meaning
// IDLE  | one-cycle restart point after reset or reload
// HDR   | collecting the 4-byte word count
// DATA  | collecting image words, one memory write per word
// DONE  | image complete, core released
// ERROR | word count exceeded capacity, core held in reset
module imem_loader
    import loader_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        reload,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst,
    output logic        load_done,
    output logic        load_error
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS) + 1;
    localparam logic [2:0] HDR_LAST = 3'(HDR_BYTES - 1);

    loader_state_t    state;
    logic [IDX_W-1:0] word_idx;
    logic [IDX_W-1:0] n_words;
    logic [2:0]       hdr_cnt;
    logic             byte_en;
    logic             asm_valid;
    logic [31:0]      asm_word;
    logic             last_word;

    assign byte_en   = in_valid && in_ready;
    assign last_word = (word_idx + IDX_W'(1)) == n_words;

    byte_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (state == IDLE),
        .byte_en    (byte_en),
        .byte_in    (in_data),
        .word       (asm_word),
        .word_valid (asm_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
            core_rst   <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            hdr_cnt    <= '0;
            word_idx   <= '0;
            n_words    <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                IDLE: begin
                    state    <= HDR;
                    in_ready <= 1'b1;
                    hdr_cnt  <= '0;
                    word_idx <= '0;
                end
                HDR: begin
                    if (byte_en) begin
                        hdr_cnt <= hdr_cnt + 3'd1;
                        if (hdr_cnt == HDR_LAST) begin
                            // Full 32-bit compare so oversized counts cannot alias into range.
                            n_words <= asm_word[IDX_W-1:0];
                            if (asm_word == 32'd0) begin
                                state     <= DONE;
                                in_ready  <= 1'b0;
                                core_rst  <= 1'b1;
                                load_done <= 1'b1;
                            end else if (asm_word > 32'(DEPTH_WORDS)) begin
                                state      <= ERROR;
                                in_ready   <= 1'b0;
                                load_error <= 1'b1;
                            end else begin
                                state <= DATA;
                            end
                        end
                    end
                end
                DATA: begin
                    if (asm_valid) begin
                        imem_we    <= 1'b1;
                        imem_wdata <= asm_word;
                        imem_addr  <= BASE_ADDR + (32'(word_idx) << 2);
                        word_idx   <= word_idx + IDX_W'(1);
                        if (last_word) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            core_rst  <= 1'b1;
                            load_done <= 1'b1;
                        end
                    end
                end
                DONE, ERROR: begin
                    if (reload) begin
                        state      <= IDLE;
                        core_rst   <= 1'b0;
                        load_done  <= 1'b0;
                        load_error <= 1'b0;
                        word_idx   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: streams images byte by byte and checks
// every write, flag and handshake against an image-level expectation.
module tb_imem_loader;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_0200;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        reload = 1'b0;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        load_done;
    logic        load_error;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] words[$];

    imem_loader #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic check_reset_vals();
        check("rst_ready",  32'(in_ready),   32'd0);
        check("rst_we",     32'(imem_we),    32'd0);
        check("rst_addr",   imem_addr,       BASE);
        check("rst_wdata",  imem_wdata,      32'd0);
        check("rst_core",   32'(core_rst),   32'd0);
        check("rst_done",   32'(load_done),  32'd0);
        check("rst_err",    32'(load_error), 32'd0);
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check("rl_core",  32'(core_rst),   32'd0);
        check("rl_done",  32'(load_done),  32'd0);
        check("rl_err",   32'(load_error), 32'd0);
        check("rl_ready", 32'(in_ready),   32'd0);
    endtask

    task automatic fill_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    // Caller is at a negedge with the DUT in IDLE. abort_at >= 0 pulses rst
    // once that many bytes have been accepted.
    task automatic stream(input logic [31:0] hdr, input int gap_pct, input int abort_at);
        logic [7:0]  bytes[$];
        logic [31:0] w;
        int          accepted = 0;
        int          idx = 0;
        int          total;
        int          cycles = 0;
        int          wi;
        bit          pending = 1'b0;
        bit          finished = 1'b0;
        bit          in_range;
        bit          ok_end;

        in_range = (hdr != 32'd0) && (hdr <= 32'(DEPTH));
        ok_end   = (hdr <= 32'(DEPTH));
        for (int k = 0; k < 4; k++) begin
            w = hdr >> (8 * k);
            bytes.push_back(w[7:0]);
        end
        if (in_range) begin
            for (int i = 0; i < int'(hdr); i++) begin
                for (int k = 0; k < 4; k++) begin
                    w = words[i] >> (8 * k);
                    bytes.push_back(w[7:0]);
                end
            end
        end
        total = bytes.size();
        check("idle_ready", 32'(in_ready), 32'd0);

        while (!finished) begin
            @(negedge clk);
            cycles++;
            if (pending) accepted++;
            if (pending && in_range && accepted > 4 && (accepted % 4) == 0) begin
                wi = accepted / 4 - 2;
                check("we",    32'(imem_we), 32'd1);
                check("addr",  imem_addr,    BASE + 32'(4 * wi));
                check("wdata", imem_wdata,   words[wi]);
            end else begin
                check("we_idle", 32'(imem_we), 32'd0);
            end
            if (pending && accepted == total) begin
                finished = 1'b1;
                check("end_done",  32'(load_done),  32'(ok_end));
                check("end_err",   32'(load_error), 32'(!ok_end));
                check("end_core",  32'(core_rst),   32'(ok_end));
                check("end_ready", 32'(in_ready),   32'd0);
            end else begin
                check("ready",     32'(in_ready), 32'd1);
                check("core_load", 32'(core_rst), 32'd0);
                check("flags_load", {30'd0, load_done, load_error}, 32'd0);
            end
            pending = 1'b0;
            reload  = 1'b0;
            if (!finished) begin
                if (abort_at >= 0 && accepted == abort_at) begin
                    rst      = 1'b0;
                    in_valid = 1'b1;
                    in_data  = 8'($urandom);
                    @(negedge clk);
                    check_reset_vals();
                    rst      = 1'b1;
                    in_valid = 1'b0;
                    return;
                end
                if (cycles > 2000) begin
                    check("timeout", 32'd1, 32'd0);
                    finished = 1'b1;
                end else if (idx < total && $urandom_range(99) >= gap_pct) begin
                    in_valid = 1'b1;
                    in_data  = bytes[idx];
                    idx++;
                    pending  = 1'b1;
                end else begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                end
                // reload during loading must be ignored
                reload = ($urandom_range(7) == 0);
            end
        end

        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            @(negedge clk);
            check("post_ready", 32'(in_ready),   32'd0);
            check("post_we",    32'(imem_we),    32'd0);
            check("post_done",  32'(load_done),  32'(ok_end));
            check("post_err",   32'(load_error), 32'(!ok_end));
            check("post_core",  32'(core_rst),   32'(ok_end));
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals();
        rst = 1'b1;

        words.delete();
        words.push_back(32'h0050_0013);
        words.push_back(32'h00A0_0093);
        stream(32'd2, 0, -1);
        do_reload();

        stream(32'd0, 0, -1);
        do_reload();

        stream(32'(DEPTH + 1), 0, -1);
        do_reload();

        fill_words(3);
        stream(32'd3, 0, -1);
        do_reload();
        stream(32'd3, 40, -1);
        do_reload();

        fill_words(4);
        stream(32'd4, 20, 10);
        stream(32'd4, 0, -1);
        do_reload();

        words.delete();
        words.push_back(32'hDEAD_BEEF);
        stream(32'd1, 0, -1);
        do_reload();

        fill_words(DEPTH);
        stream(32'(DEPTH), 10, -1);
        do_reload();

        stream(32'hFFFF_FFFF, 0, -1);
        do_reload();

        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(DEPTH);
            fill_words(n);
            stream(32'(n), $urandom_range(50), -1);
            do_reload();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
